// File: rtl/noc_mem_responder.sv
// rtl/noc_mem_responder.sv - NoC memory responder: request FIFO, fixed-latency FSM, 64-bit backing store
module noc_mem_responder #(
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] ni_req_addr,
  input  logic [63:0] ni_req_data,
  input  logic [7:0]  ni_req_type,
  input  logic        ni_req_valid,
  output logic        ni_req_ready,
  output logic [63:0] ni_resp_data,
  output logic [7:0]  ni_resp_type,
  output logic        ni_resp_valid,
  input  logic        ni_resp_ready,
  output logic        err_unsupported,
  output logic [15:0] err_count
);

  localparam int IDX_W   = $clog2(MEM_WORDS);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 48 + 64 + 8;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_LAT = 2'd1;
  localparam logic [1:0] S_RESPOND  = 2'd2;

  localparam logic [7:0] T_READ  = 8'h01;
  localparam logic [7:0] T_WRITE = 8'h02;
  localparam logic [7:0] T_FETCH = 8'h03;

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count, count_next;
  logic [63:0]        mem [MEM_WORDS];

  logic [1:0]         state;
  logic [7:0]         cnt;
  logic [IDX_W-1:0]   w_idx;
  logic [63:0]        w_data;
  logic [7:0]         w_type;

  logic               push, pop, head_known;
  logic [ENTRY_W-1:0] head;
  logic [47:0]        head_addr;
  logic [63:0]        head_data;
  logic [7:0]         head_type;
  logic               unused_addr_bits;

  assign push      = ni_req_valid && ni_req_ready;
  assign pop       = (state == S_IDLE) && (count != '0);
  assign head      = fifo_mem[rd_ptr];
  assign head_addr = head[ENTRY_W-1 -: 48];
  assign head_data = head[71:8];
  assign head_type = head[7:0];
  assign head_known = (head_type == T_READ) || (head_type == T_WRITE) || (head_type == T_FETCH);
  assign unused_addr_bits = ^{head_addr[47:IDX_W+3], head_addr[2:0]};

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Queue and memory storage carry no reset; only pointers and control are cleared.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {ni_req_addr, ni_req_data, ni_req_type};
  end

  always_ff @(posedge clk) begin
    if (!reset && state == S_WAIT_LAT && cnt == 8'd0 && w_type == T_WRITE)
      mem[w_idx] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      state           <= S_IDLE;
      cnt             <= 8'd0;
      w_idx           <= '0;
      w_data          <= 64'd0;
      w_type          <= 8'd0;
      ni_req_ready    <= 1'b0;
      ni_resp_valid   <= 1'b0;
      ni_resp_data    <= 64'd0;
      ni_resp_type    <= 8'd0;
      err_unsupported <= 1'b0;
      err_count       <= 16'd0;
    end else begin
      count           <= count_next;
      ni_req_ready    <= (count_next != FULL_CNT);
      err_unsupported <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case (state)
        S_IDLE: begin
          if (pop) begin
            if (head_known) begin
              w_idx  <= head_addr[IDX_W+2:3];
              w_data <= head_data;
              w_type <= head_type;
              cnt    <= 8'(LATENCY - 1);
              state  <= S_WAIT_LAT;
            end else begin
              err_unsupported <= 1'b1;
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
          end
        end
        S_WAIT_LAT: begin
          if (cnt == 8'd0) begin
            state         <= S_RESPOND;
            ni_resp_valid <= 1'b1;
            case (w_type)
              T_WRITE: begin ni_resp_data <= 64'd0;     ni_resp_type <= 8'h82; end
              T_READ:  begin ni_resp_data <= mem[w_idx]; ni_resp_type <= 8'h81; end
              default: begin ni_resp_data <= mem[w_idx]; ni_resp_type <= 8'h83; end
            endcase
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_RESPOND: begin
          if (ni_resp_ready) begin
            ni_resp_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_mem_responder.sv
// tb/tb_noc_mem_responder.sv - directed self-checking bench for noc_mem_responder
module tb_noc_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] ni_req_addr;
  logic [63:0] ni_req_data;
  logic [7:0]  ni_req_type;
  logic        ni_req_valid;
  logic        ni_req_ready;
  logic [63:0] ni_resp_data;
  logic [7:0]  ni_resp_type;
  logic        ni_resp_valid;
  logic        ni_resp_ready;
  logic        err_unsupported;
  logic [15:0] err_count;

  localparam logic [63:0] DATA0 = 64'hDEADBEEF_CAFEF00D;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int seen_cyc = 0;

  noc_mem_responder #(.MEM_WORDS(1024), .LATENCY(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .ni_req_addr(ni_req_addr), .ni_req_data(ni_req_data), .ni_req_type(ni_req_type),
    .ni_req_valid(ni_req_valid), .ni_req_ready(ni_req_ready),
    .ni_resp_data(ni_resp_data), .ni_resp_type(ni_resp_type),
    .ni_resp_valid(ni_resp_valid), .ni_resp_ready(ni_resp_ready),
    .err_unsupported(err_unsupported), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] t, input logic [47:0] a, input logic [63:0] d, output int acc);
    int n = 0;
    @(negedge clk);
    ni_req_type = t; ni_req_addr = a; ni_req_data = d; ni_req_valid = 1'b1;
    while (!ni_req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    ni_req_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_resp(input string tag, input logic [7:0] t, input logic [63:0] d);
    int n = 0;
    @(negedge clk);
    while (!ni_resp_valid && n < 100) begin @(negedge clk); n++; end
    check({tag, "_valid"}, 64'(ni_resp_valid), 64'd1);
    check({tag, "_type"}, 64'(ni_resp_type), 64'(t));
    check({tag, "_data"}, ni_resp_data, d);
    seen_cyc = cyc;
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, n, hi_err, hi_resp;
    reset = 1'b1; ni_req_addr = '0; ni_req_data = '0; ni_req_type = '0;
    ni_req_valid = 1'b0; ni_resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(ni_req_ready), 64'd0);
    check("rst_valid", 64'(ni_resp_valid), 64'd0);
    check("rst_data", ni_resp_data, 64'd0);
    check("rst_type", 64'(ni_resp_type), 64'd0);
    check("rst_err", 64'(err_unsupported), 64'd0);
    check("rst_errcnt", 64'(err_count), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(ni_req_ready), 64'd1);

    send(8'h02, 48'h40, DATA0, acc);
    wait_resp("wr40", 8'h82, 64'd0);
    check("wr40_lat", 64'(seen_cyc - acc), 64'd5);
    send(8'h01, 48'h40, 64'd0, acc);
    wait_resp("rd40", 8'h81, DATA0);
    check("rd40_lat", 64'(seen_cyc - acc), 64'd5);

    send(8'h02, 48'h2000, 64'h1111, acc);
    wait_resp("wr2000", 8'h82, 64'd0);
    send(8'h03, 48'h0, 64'd0, acc);
    wait_resp("fetch0", 8'h83, 64'h1111);
    send(8'h03, 48'h7, 64'd0, acc);
    wait_resp("fetch7", 8'h83, 64'h1111);

    for (int i = 0; i < 5; i++) begin
      send(8'h02, 48'h100 + 48'(8 * i), 64'hA0A0_0000_0000_0000 | 64'(i), acc);
      wait_resp("bp_fill", 8'h82, 64'd0);
    end
    ni_resp_ready = 1'b0;
    send(8'h01, 48'h100, 64'd0, acc);
    n = 0;
    while (!ni_resp_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_first_valid", 64'(ni_resp_valid), 64'd1);
    for (int i = 1; i < 5; i++) send(8'h01, 48'h100 + 48'(8 * i), 64'd0, acc);
    @(negedge clk);
    check("bp_full_ready", 64'(ni_req_ready), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(ni_resp_valid), 64'd1);
      check("bp_hold_type", 64'(ni_resp_type), 64'h81);
      check("bp_hold_data", ni_resp_data, 64'hA0A0_0000_0000_0000);
      check("bp_hold_ready", 64'(ni_req_ready), 64'd0);
    end
    @(posedge clk); #1;
    ni_resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) wait_resp("bp_order", 8'h81, 64'hA0A0_0000_0000_0000 | 64'(i));

    send(8'h07, 48'h40, 64'd0, acc);
    hi_err = 0; hi_resp = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (err_unsupported) hi_err++;
      if (ni_resp_valid) hi_resp++;
    end
    check("unsup_pulse", 64'(hi_err), 64'd1);
    check("unsup_noresp", 64'(hi_resp), 64'd0);
    check("unsup_errcnt", 64'(err_count), 64'd1);
    send(8'h01, 48'h40, 64'd0, acc);
    wait_resp("unsup_next_rd", 8'h81, DATA0);

    send(8'h01, 48'h40, 64'd0, acc);
    send(8'h01, 48'h108, 64'd0, acc);
    send(8'h01, 48'h110, 64'd0, acc);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_ready_low", 64'(ni_req_ready), 64'd0);
    @(posedge clk); #1;
    check("mid_rst_ready_high", 64'(ni_req_ready), 64'd1);
    hi_resp = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ni_resp_valid) hi_resp++;
    end
    check("mid_rst_noresp", 64'(hi_resp), 64'd0);
    check("mid_rst_errcnt", 64'(err_count), 64'd0);
    send(8'h01, 48'h40, 64'd0, acc);
    wait_resp("mid_rst_rd40", 8'h81, DATA0);
    check("mid_rst_lat", 64'(seen_cyc - acc), 64'd5);
    send(8'h01, 48'h108, 64'd0, acc);
    wait_resp("mid_rst_rd108", 8'h81, 64'hA0A0_0000_0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
